mac_acc_pipe: RTL and testbench

Parametrised, pipelined multiply-accumulate engine with valid/ready handshakes on input and output. It is the successor to the combinational 16-bit multiply-add unit. It adds configurable operand and accumulator widths, multi-beat frame accumulation with a bias term, a term counter and overflow reporting. It also keeps the approximate-product option: low product bits can be forced to zero. It sits between an operand source (FIFO or DMA) and a result sink in the datapath.

---
 rtl/mac_acc_pipe.sv | 143 ++++++++++++++
 tb/tb_mac_acc_pipe.sv | 321 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mac_acc_pipe.sv
// Pipelined multiply-accumulate engine with valid/ready handshakes, frame accumulation and overflow flag.
// Build option: define MAC_ACC_SAT_EN to saturate the accumulator on carry-out instead of wrapping.
module mac_acc_pipe #(
  parameter int unsigned DATA_W     = 16,
  parameter int unsigned ACC_W      = 40,
  parameter int unsigned CNT_W      = 8,
  parameter int unsigned APPROX_LSB = 0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_a,
  input  logic [DATA_W-1:0] in_b,
  input  logic [DATA_W-1:0] in_c,
  input  logic              in_first,
  input  logic              in_last,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [ACC_W-1:0]  out_acc,
  output logic [CNT_W-1:0]  out_cnt,
  output logic              out_ovf
);

  localparam int unsigned    PW    = 2 * DATA_W;
  localparam logic [PW-1:0]  PMASK = {PW{1'b1}} << APPROX_LSB;

  logic              stall;

  // S1: registered operands
  logic              v1;
  logic [DATA_W-1:0] a1, b1, c1;
  logic              first1, last1;

  // S2: registered (possibly truncated) product
  logic              v2;
  logic [PW-1:0]     p2;
  logic [DATA_W-1:0] c2;
  logic              first2, last2;
  logic [PW-1:0]     prod1;

  // S3: running frame state
  logic [ACC_W-1:0]  acc;
  logic [CNT_W-1:0]  cnt;
  logic              ovf;
  logic              done3;

  logic [ACC_W-1:0]  base, p_ext, acc_nx;
  logic [ACC_W:0]    sum_w;
  logic              carry;
  logic [CNT_W-1:0]  cnt_nx;
  logic              ovf_nx;

  assign stall    = out_valid && !out_ready;
  assign in_ready = !out_valid || out_ready;

  always_ff @(posedge clk) begin
    if (rst) begin
      v1     <= 1'b0;
      a1     <= '0;
      b1     <= '0;
      c1     <= '0;
      first1 <= 1'b0;
      last1  <= 1'b0;
    end else if (!stall) begin
      v1     <= in_valid;
      a1     <= in_a;
      b1     <= in_b;
      c1     <= in_c;
      first1 <= in_first;
      last1  <= in_last;
    end
  end

  always_comb begin
    prod1 = {{DATA_W{1'b0}}, a1} * {{DATA_W{1'b0}}, b1};
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      v2     <= 1'b0;
      p2     <= '0;
      c2     <= '0;
      first2 <= 1'b0;
      last2  <= 1'b0;
    end else if (!stall) begin
      v2     <= v1;
      p2     <= prod1 & PMASK;
      c2     <= c1;
      first2 <= first1;
      last2  <= last1;
    end
  end

  // A first beat restarts from the bias, dropping any partial frame in acc.
  always_comb begin
    p_ext  = ACC_W'(p2);
    base   = first2 ? ACC_W'(c2) : acc;
    sum_w  = {1'b0, base} + {1'b0, p_ext};
    carry  = sum_w[ACC_W];
`ifdef MAC_ACC_SAT_EN
    acc_nx = carry ? '1 : sum_w[ACC_W-1:0];
`else
    acc_nx = sum_w[ACC_W-1:0];
`endif
    cnt_nx = first2 ? CNT_W'(1) : cnt + CNT_W'(1);
    ovf_nx = first2 ? carry : (ovf | carry);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      acc   <= '0;
      cnt   <= '0;
      ovf   <= 1'b0;
      done3 <= 1'b0;
    end else if (!stall) begin
      done3 <= v2 && last2;
      if (v2) begin
        acc <= acc_nx;
        cnt <= cnt_nx;
        ovf <= ovf_nx;
      end
    end
  end

  // Output register loads the frame state one edge after the last beat updates it.
  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid <= 1'b0;
      out_acc   <= '0;
      out_cnt   <= '0;
      out_ovf   <= 1'b0;
    end else if (!stall) begin
      out_valid <= done3;
      if (done3) begin
        out_acc <= acc;
        out_cnt <= cnt;
        out_ovf <= ovf;
      end
    end
  end

endmodule

// File: tb/tb_mac_acc_pipe.sv
// Self-checking bench for mac_acc_pipe: exact and approximate instances share stimulus and a frame-level model.
module tb_mac_acc_pipe;

  localparam int unsigned DW = 8;
  localparam int unsigned AW = 16;
  localparam int unsigned CW = 3;
  localparam int unsigned AL = 4;
`ifdef MAC_ACC_SAT_EN
  localparam bit SAT = 1'b1;
`else
  localparam bit SAT = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          in_valid = 1'b0;
  logic [DW-1:0] in_a = '0, in_b = '0, in_c = '0;
  logic          in_first = 1'b0, in_last = 1'b0;
  logic          out_ready = 1'b1;

  logic          in_ready0, in_ready1, out_valid0, out_valid1, out_ovf0, out_ovf1;
  logic [AW-1:0] out_acc0, out_acc1;
  logic [CW-1:0] out_cnt0, out_cnt1;

  int nchecks = 0;
  int nerrors = 0;
  bit armed = 1'b0;

  always #5 clk = ~clk;

  mac_acc_pipe #(.DATA_W(DW), .ACC_W(AW), .CNT_W(CW), .APPROX_LSB(0)) u0 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready0),
    .in_a(in_a), .in_b(in_b), .in_c(in_c), .in_first(in_first), .in_last(in_last),
    .out_valid(out_valid0), .out_ready(out_ready), .out_acc(out_acc0),
    .out_cnt(out_cnt0), .out_ovf(out_ovf0)
  );

  mac_acc_pipe #(.DATA_W(DW), .ACC_W(AW), .CNT_W(CW), .APPROX_LSB(AL)) u1 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready1),
    .in_a(in_a), .in_b(in_b), .in_c(in_c), .in_first(in_first), .in_last(in_last),
    .out_valid(out_valid1), .out_ready(out_ready), .out_acc(out_acc1),
    .out_cnt(out_cnt1), .out_ovf(out_ovf1)
  );

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    nchecks++;
    if (act !== exp) begin
      nerrors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Frame-level model: results computed per accepted beat, queued in order of completion.
  typedef struct {
    logic [AW-1:0] acc0;
    logic [AW-1:0] acc1;
    logic [CW-1:0] cnt;
    logic          ovf0;
    logic          ovf1;
  } res_t;

  res_t          q[$];
  logic [AW-1:0] m_acc[2];
  logic          m_ovf[2];
  logic [CW-1:0] m_cnt;
  res_t          m_last;

  function automatic logic [AW-1:0] prod(input logic [DW-1:0] a, input logic [DW-1:0] b,
                                         input int unsigned lsb);
    logic [2*DW-1:0] p;
    p = {{DW{1'b0}}, a} * {{DW{1'b0}}, b};
    p = (p >> lsb) << lsb;
    return AW'(p);
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 2; i++) begin
      m_acc[i] = '0;
      m_ovf[i] = 1'b0;
    end
    m_cnt = '0;
    q.delete();
  endtask

  task automatic model_step(input logic [DW-1:0] a, input logic [DW-1:0] b, input logic [DW-1:0] c,
                            input logic first, input logic last);
    logic [AW:0] s;
    res_t r;
    for (int i = 0; i < 2; i++) begin
      if (first) s = {1'b0, AW'(c)} + {1'b0, prod(a, b, (i == 0) ? 0 : AL)};
      else       s = {1'b0, m_acc[i]} + {1'b0, prod(a, b, (i == 0) ? 0 : AL)};
      m_ovf[i] = first ? s[AW] : (m_ovf[i] | s[AW]);
      m_acc[i] = (SAT && s[AW]) ? '1 : s[AW-1:0];
    end
    m_cnt = first ? CW'(1) : m_cnt + CW'(1);
    if (last) begin
      r.acc0 = m_acc[0]; r.acc1 = m_acc[1]; r.cnt = m_cnt;
      r.ovf0 = m_ovf[0]; r.ovf1 = m_ovf[1];
      q.push_back(r);
      m_last = r;
    end
  endtask

  logic          prev_stall = 1'b0;
  logic [AW-1:0] prev_acc;
  res_t          rr;

  always @(negedge clk) begin
    if (armed) begin
      chk("in_ready", 64'(in_ready0), 64'(!out_valid0 || out_ready));
      chk("in_ready_apx", 64'(in_ready1), 64'(!out_valid1 || out_ready));
      chk("valid_apx", 64'(out_valid1), 64'(out_valid0));
      if (prev_stall) begin
        chk("hold_valid", 64'(out_valid0), 64'(1));
        chk("hold_acc", 64'(out_acc0), 64'(prev_acc));
      end
      if (out_valid0 === 1'b1) begin
        if (q.size() == 0) begin
          chk("spurious_out", 64'(out_valid0), 64'(0));
        end else begin
          rr = q[0];
          chk("out_acc", 64'(out_acc0), 64'(rr.acc0));
          chk("out_cnt", 64'(out_cnt0), 64'(rr.cnt));
          chk("out_ovf", 64'(out_ovf0), 64'(rr.ovf0));
          chk("out_acc_apx", 64'(out_acc1), 64'(rr.acc1));
          chk("out_cnt_apx", 64'(out_cnt1), 64'(rr.cnt));
          chk("out_ovf_apx", 64'(out_ovf1), 64'(rr.ovf1));
          if (out_ready) rr = q.pop_front();
        end
      end
      prev_stall = out_valid0 && !out_ready && !rst;
      prev_acc   = out_acc0;
    end
    if (rst) begin
      model_reset();
      prev_stall = 1'b0;
    end else if (in_valid && in_ready0 === 1'b1) begin
      model_step(in_a, in_b, in_c, in_first, in_last);
    end
  end

  task automatic send(input logic [DW-1:0] a, input logic [DW-1:0] b, input logic [DW-1:0] c,
                      input logic first, input logic last, output bit stalled);
    bit rdy;
    int n;
    in_valid = 1'b1; in_a = a; in_b = b; in_c = c; in_first = first; in_last = last;
    stalled = 1'b0;
    n = 0;
    forever begin
      @(negedge clk);
      rdy = in_ready0;
      @(posedge clk);
      #1;
      if (rdy) break;
      stalled = 1'b1;
      n++;
      if (n > 100) begin
        chk("send_timeout", 64'(0), 64'(1));
        break;
      end
    end
  endtask

  task automatic wait_out();
    int n;
    n = 0;
    in_valid = 1'b0;
    forever begin
      @(negedge clk);
      if (out_valid0 === 1'b1) break;
      n++;
      if (n > 50) begin
        chk("wait_out_timeout", 64'(0), 64'(1));
        break;
      end
    end
  endtask

  bit st;

  initial begin
    repeat (3) @(posedge clk);
    armed = 1'b1;
    @(negedge clk);
    chk("rst_out_valid", 64'(out_valid0), 64'(0));
    chk("rst_out_acc", 64'(out_acc0), 64'(0));
    chk("rst_out_cnt", 64'(out_cnt0), 64'(0));
    chk("rst_out_ovf", 64'(out_ovf0), 64'(0));
    chk("rst_in_ready", 64'(in_ready0), 64'(1));
    @(posedge clk); #1;
    rst = 1'b0;

    // single-beat frame and its three-edge latency
    send(3, 5, 7, 1, 1, st);
    in_valid = 1'b0;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      chk("latency", 64'(out_valid0), 64'(k == 3));
    end
    chk("t1_acc", 64'(out_acc0), 64'(22));
    chk("t1_cnt", 64'(out_cnt0), 64'(1));
    chk("t1_ovf", 64'(out_ovf0), 64'(0));
    chk("t1_acc_apx", 64'(out_acc1), 64'(7));
    chk("t1_model", 64'(m_last.acc0), 64'(22));
    @(posedge clk); #1;

    // back-to-back four-beat frame
    send(2, 3, 10, 1, 0, st); chk("t2_ready", 64'(st), 64'(0));
    send(4, 5, 0, 0, 0, st);  chk("t2_ready", 64'(st), 64'(0));
    send(6, 7, 0, 0, 0, st);  chk("t2_ready", 64'(st), 64'(0));
    send(1, 1, 0, 0, 1, st);  chk("t2_ready", 64'(st), 64'(0));
    wait_out();
    chk("t2_acc", 64'(out_acc0), 64'(79));
    chk("t2_cnt", 64'(out_cnt0), 64'(4));
    chk("t2_acc_apx", 64'(out_acc1), 64'(58));
    @(posedge clk); #1;

    // backpressure while a second frame streams in
    out_ready = 1'b0;
    send(3, 5, 7, 1, 1, st);
    fork
      begin
        bit s2;
        send(2, 3, 10, 1, 0, s2);
        send(4, 5, 0, 0, 0, s2);
        send(6, 7, 0, 0, 0, s2);
        send(1, 1, 0, 0, 1, s2);
        in_valid = 1'b0;
      end
      begin
        int n;
        n = 0;
        do begin
          @(negedge clk);
          n++;
        end while (out_valid0 !== 1'b1 && n < 50);
        for (int k = 0; k < 5; k++) begin
          if (k > 0) @(negedge clk);
          chk("t3_in_ready", 64'(in_ready0), 64'(0));
          chk("t3_acc_hold", 64'(out_acc0), 64'(22));
        end
        @(posedge clk); #1;
        out_ready = 1'b1;
      end
    join
    wait_out();
    chk("t3_acc2", 64'(out_acc0), 64'(79));
    chk("t3_cnt2", 64'(out_cnt0), 64'(4));
    @(posedge clk); #1;

    // accumulator overflow
    send(8'hFF, 8'hFF, 0, 1, 0, st);
    send(8'hFF, 8'hFF, 0, 0, 1, st);
    wait_out();
    chk("t4_acc", 64'(out_acc0), SAT ? 64'hFFFF : 64'hFC02);
    chk("t4_ovf", 64'(out_ovf0), 64'(1));
    chk("t4_cnt", 64'(out_cnt0), 64'(2));
    @(posedge clk); #1;

    // approximate product on the second instance
    send(3, 5, 0, 1, 1, st);
    wait_out();
    chk("t5_apx_a", 64'(out_acc1), 64'(0));
    chk("t5_exact_a", 64'(out_acc0), 64'(15));
    @(posedge clk); #1;
    send(17, 1, 0, 1, 1, st);
    wait_out();
    chk("t5_apx_b", 64'(out_acc1), 64'(16));
    @(posedge clk); #1;

    // term counter wraps modulo 2^CW
    send(1, 1, 0, 1, 0, st);
    for (int k = 0; k < 7; k++) send(1, 1, 0, 0, 0, st);
    send(1, 1, 0, 0, 1, st);
    wait_out();
    chk("cnt_wrap_acc", 64'(out_acc0), 64'(9));
    chk("cnt_wrap_cnt", 64'(out_cnt0), 64'(1));
    @(posedge clk); #1;

    // reset mid-frame with a last beat in flight: nothing emitted
    send(9, 9, 3, 1, 0, st);
    send(7, 7, 0, 0, 1, st);
    in_valid = 1'b0;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    repeat (5) begin
      @(negedge clk);
      chk("t6_no_out", 64'(out_valid0), 64'(0));
    end
    @(posedge clk); #1;
    send(2, 2, 0, 1, 1, st);
    wait_out();
    chk("t6_acc", 64'(out_acc0), 64'(4));
    chk("t6_cnt", 64'(out_cnt0), 64'(1));
    @(posedge clk); #1;

    // randomized traffic with backpressure, frame restarts and occasional reset
    for (int i = 0; i < 3000; i++) begin
      in_valid  = ($urandom_range(0, 3) != 0);
      in_a      = ($urandom_range(0, 3) == 0) ? 8'hFF : DW'($urandom);
      in_b      = ($urandom_range(0, 3) == 0) ? 8'hFF : DW'($urandom);
      in_c      = DW'($urandom);
      in_first  = ($urandom_range(0, 5) == 0);
      in_last   = ($urandom_range(0, 4) == 0);
      out_ready = ($urandom_range(0, 9) < 7);
      rst       = ($urandom_range(0, 299) == 0);
      @(posedge clk); #1;
    end
    rst = 1'b0;
    in_valid = 1'b0;
    out_ready = 1'b1;
    repeat (10) @(posedge clk);
    #1;
    chk("drain_empty", 64'(q.size()), 64'(0));

    $display("Simulation finished: %0d checks, %0d errors", nchecks, nerrors);
    $finish;
  end

endmodule
